// File: rtl/move_tracker_if.sv
// Move tracker bus: the move handshake coming from the rat solver and the
// position/status report going back out. The master drives moves, the slave
// (the tracker) drives everything else.
interface move_tracker_if;
    logic       move_valid;
    logic [1:0] move;
    logic       move_ready;
    logic [3:0] pos_row;
    logic [3:0] pos_col;
    logic       pos_valid;
    logic [7:0] step_cnt;
    logic       arrived;
    logic       oob_err;

    modport master (
        output move_valid, move,
        input  move_ready, pos_row, pos_col, pos_valid, step_cnt, arrived, oob_err
    );

    modport slave (
        input  move_valid, move,
        output move_ready, pos_row, pos_col, pos_valid, step_cnt, arrived, oob_err
    );
endinterface

// File: rtl/move_tracker.sv
// Move tracker: buffers rat-solver moves in a small FIFO and applies one move
// every STEP_DIV cycles to a position on a 16x16 grid. A move that would leave
// the grid parks the tracker in ERROR; reaching the goal parks it in ARRIVED.
// Both are sticky until clr or rst. DEPTH must be a power of two, at least 2.
module move_tracker #(
    parameter int         STEP_DIV = 4,
    parameter int         DEPTH    = 4,
    parameter logic [3:0] GOAL_ROW = 4'd15,
    parameter logic [3:0] GOAL_COL = 4'd15
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clr,
    move_tracker_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WALK    = 2'd1,
        S_ARRIVED = 2'd2,
        S_ERROR   = 2'd3
    } state_t;

    // Apply one move code to a position; returns {out_of_grid, row, col}.
    // On an out-of-grid move the original position is returned unchanged.
    function automatic logic [8:0] f_apply(input logic [3:0] row,
                                           input logic [3:0] col,
                                           input logic [1:0] mv);
        logic       oob;
        logic [3:0] nrow;
        logic [3:0] ncol;
        oob  = 1'b0;
        nrow = row;
        ncol = col;
        case (mv)
            2'b00: begin
                if (row == 4'd0) oob = 1'b1;
                else             nrow = row - 4'd1;
            end
            2'b01: begin
                if (col == 4'd15) oob = 1'b1;
                else              ncol = col + 4'd1;
            end
            2'b10: begin
                if (col == 4'd0) oob = 1'b1;
                else             ncol = col - 4'd1;
            end
            2'b11: begin
                if (row == 4'd15) oob = 1'b1;
                else              nrow = row + 4'd1;
            end
            default: oob = 1'b1;
        endcase
        return {oob, nrow, ncol};
    endfunction

    state_t        r_state;
    logic [1:0]    r_fifo [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_pace;
    logic [3:0]    r_row;
    logic [3:0]    r_col;
    logic          r_pos_valid;
    logic [7:0]    r_step;

    logic          w_full;
    logic          w_empty;
    logic          w_ready;
    logic          w_push;
    logic          w_tick;
    logic          w_pop;
    logic [1:0]    w_head;
    logic          w_oob;
    logic [3:0]    w_nrow;
    logic [3:0]    w_ncol;
    logic          w_goal;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == {CW{1'b0}});
    // Only the two "live" states take moves; ARRIVED/ERROR freeze the buffer.
    assign w_ready = ((r_state == S_IDLE) || (r_state == S_WALK)) && !w_full;
    assign w_push  = bus.move_valid && w_ready;
    assign w_tick  = (r_state == S_WALK) && (r_pace == 8'(STEP_DIV - 1));
    assign w_pop   = w_tick && !w_empty;
    assign w_head  = r_fifo[r_rptr];
    assign {w_oob, w_nrow, w_ncol} = f_apply(r_row, r_col, w_head);
    assign w_goal  = (w_nrow == GOAL_ROW) && (w_ncol == GOAL_COL);

    assign bus.move_ready = w_ready;
    assign bus.pos_row    = r_row;
    assign bus.pos_col    = r_col;
    assign bus.pos_valid  = r_pos_valid;
    assign bus.step_cnt   = r_step;
    assign bus.arrived    = (r_state == S_ARRIVED);
    assign bus.oob_err    = (r_state == S_ERROR);

    // FIFO storage: write the offered move into the tail slot on an accepted push.
    always_ff @(posedge clk) begin
        if (w_push && !rst && !clr) begin
            r_fifo[r_wptr] <= bus.move;
        end
    end

    // Control FSM, FIFO pointers/occupancy, pacing and position registers.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_state     <= S_IDLE;
            r_wptr      <= {AW{1'b0}};
            r_rptr      <= {AW{1'b0}};
            r_count     <= {CW{1'b0}};
            r_pace      <= 8'd0;
            r_row       <= 4'd0;
            r_col       <= 4'd0;
            r_pos_valid <= 1'b0;
            r_step      <= 8'd0;
        end else begin
            r_pos_valid <= 1'b0;

            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (w_push) begin
                        r_state <= S_WALK;
                        r_pace  <= 8'd0;
                    end
                end
                S_WALK: begin
                    r_pace <= w_tick ? 8'd0 : (r_pace + 8'd1);
                    if (w_pop) begin
                        if (w_oob) begin
                            r_state <= S_ERROR;
                        end else begin
                            r_row       <= w_nrow;
                            r_col       <= w_ncol;
                            r_pos_valid <= 1'b1;
                            r_step      <= (r_step == 8'd255) ? r_step : (r_step + 8'd1);
                            if (w_goal) r_state <= S_ARRIVED;
                        end
                    end
                end
                S_ARRIVED: r_state <= S_ARRIVED;
                S_ERROR:   r_state <= S_ERROR;
                default:   r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_move_tracker.sv
// Directed bench for move_tracker with default parameters
// (STEP_DIV=4, DEPTH=4, goal (15,15)).
module tb_move_tracker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clr = 1'b0;

    move_tracker_if bus();

    move_tracker dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // {ready,row,col,pos_valid,step,arrived,oob}
    localparam logic [19:0] RST_SNAP = {1'b1, 4'd0, 4'd0, 1'b0, 8'd0, 1'b0, 1'b0};

    function automatic logic [19:0] snap();
        return {bus.move_ready, bus.pos_row, bus.pos_col, bus.pos_valid,
                bus.step_cnt, bus.arrived, bus.oob_err};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        bus.move_valid = 1'b0;
        bus.move       = 2'b00;
        rst = 1'b1;
        cyc();
        checks++;
        if (snap() !== RST_SNAP) begin
            errors++;
            $display("FAIL reset_held: got %h expected %h", snap(), RST_SNAP);
        end
        rst = 1'b0;
        cyc();
        checks++;
        if (snap() !== RST_SNAP) begin
            errors++;
            $display("FAIL reset_released: got %h expected %h", snap(), RST_SNAP);
        end
    endtask

    task automatic test_latency();
        int pulses = 0;
        bus.move_valid = 1'b1;
        bus.move       = 2'b01;
        cyc();
        bus.move_valid = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            if (bus.pos_valid) pulses++;
            if (i == 5) begin
                checks++;
                if ({bus.pos_valid, bus.pos_row, bus.pos_col, bus.step_cnt} !==
                    {1'b1, 4'd0, 4'd1, 8'd1}) begin
                    errors++;
                    $display("FAIL latency_pos: got pv=%b pos=(%0d,%0d) step=%0d expected pv=1 pos=(0,1) step=1",
                             bus.pos_valid, bus.pos_row, bus.pos_col, bus.step_cnt);
                end
            end
            cyc();
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL latency_pulses: got %0d expected 1", pulses);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] mv [5];
        int         acc = 0;
        int         blocked_at = -1;
        logic [7:0] step_at5 = 8'hxx;
        mv[0] = 2'b11; mv[1] = 2'b01; mv[2] = 2'b11; mv[3] = 2'b01; mv[4] = 2'b11;
        pulse_clr();
        for (int c = 0; c < 40 && acc < 5; c++) begin
            bus.move_valid = 1'b1;
            bus.move       = mv[acc];
            if (bus.move_ready) begin
                if (acc == 4) step_at5 = bus.step_cnt;
                acc++;
            end else if (blocked_at < 0) begin
                blocked_at = acc;
            end
            cyc();
        end
        bus.move_valid = 1'b0;
        checks++;
        if (blocked_at !== 4) begin
            errors++;
            $display("FAIL bp_first_block: got %0d accepts expected 4", blocked_at);
        end
        checks++;
        if (step_at5 !== 8'd1) begin
            errors++;
            $display("FAIL bp_fifth_after_tick: got step %0d expected 1", step_at5);
        end
        for (int c = 0; c < 60 && bus.step_cnt != 8'd5; c++) cyc();
        cyc();
        checks++;
        if ({bus.pos_row, bus.pos_col, bus.step_cnt, bus.oob_err, bus.arrived, bus.move_ready} !==
            {4'd3, 4'd2, 8'd5, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL bp_final: got pos=(%0d,%0d) step=%0d oob=%b arr=%b rdy=%b expected (3,2) 5 0 0 1",
                     bus.pos_row, bus.pos_col, bus.step_cnt, bus.oob_err, bus.arrived, bus.move_ready);
        end
    endtask

    task automatic test_arrival();
        int acc = 0;
        pulse_clr();
        for (int c = 0; c < 300 && acc < 30; c++) begin
            bus.move_valid = 1'b1;
            bus.move       = (acc < 15) ? 2'b11 : 2'b01;
            if (bus.move_ready) acc++;
            cyc();
        end
        bus.move_valid = 1'b0;
        for (int c = 0; c < 200 && !bus.arrived; c++) cyc();
        checks++;
        if ({bus.arrived, bus.pos_valid, bus.pos_row, bus.pos_col, bus.step_cnt, bus.move_ready, bus.oob_err} !==
            {1'b1, 1'b1, 4'd15, 4'd15, 8'd30, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL arrival: got arr=%b pv=%b pos=(%0d,%0d) step=%0d rdy=%b oob=%b expected 1 1 (15,15) 30 0 0",
                     bus.arrived, bus.pos_valid, bus.pos_row, bus.pos_col, bus.step_cnt,
                     bus.move_ready, bus.oob_err);
        end
        bus.move_valid = 1'b1;
        bus.move       = 2'b00;
        for (int c = 0; c < 8; c++) cyc();
        bus.move_valid = 1'b0;
        checks++;
        if (snap() !== {1'b0, 4'd15, 4'd15, 1'b0, 8'd30, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL arrival_sticky: got %h expected %h", snap(),
                     {1'b0, 4'd15, 4'd15, 1'b0, 8'd30, 1'b1, 1'b0});
        end
    endtask

    task automatic test_restart();
        int   pulses = 0;
        logic rdy_seen;
        clr = 1'b1;
        bus.move_valid = 1'b1;
        bus.move       = 2'b01;
        cyc();
        clr = 1'b0;
        bus.move_valid = 1'b0;
        checks++;
        if (snap() !== RST_SNAP) begin
            errors++;
            $display("FAIL restart_clr: got %h expected %h", snap(), RST_SNAP);
        end
        for (int c = 0; c < 10; c++) begin
            if (bus.pos_valid) pulses++;
            cyc();
        end
        checks++;
        if (snap() !== RST_SNAP || pulses !== 0) begin
            errors++;
            $display("FAIL restart_fifo_empty: got %h pulses %0d expected %h pulses 0",
                     snap(), pulses, RST_SNAP);
        end
        clr = 1'b1;
        bus.move_valid = 1'b1;
        bus.move       = 2'b11;
        rdy_seen = bus.move_ready;
        cyc();
        clr = 1'b0;
        bus.move_valid = 1'b0;
        for (int c = 0; c < 10; c++) cyc();
        checks++;
        if (rdy_seen !== 1'b1 || snap() !== RST_SNAP) begin
            errors++;
            $display("FAIL clr_drops_move: got rdy=%b snap %h expected rdy=1 snap %h",
                     rdy_seen, snap(), RST_SNAP);
        end
    endtask

    task automatic test_error();
        int pulses = 0;
        pulse_clr();
        bus.move_valid = 1'b1;
        bus.move       = 2'b00;
        cyc();
        bus.move_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (bus.pos_valid) pulses++;
            cyc();
        end
        checks++;
        if ({bus.oob_err, bus.pos_row, bus.pos_col, bus.step_cnt, bus.arrived, bus.move_ready} !==
            {1'b1, 4'd0, 4'd0, 8'd0, 1'b0, 1'b0} || pulses !== 0) begin
            errors++;
            $display("FAIL error_up: got oob=%b pos=(%0d,%0d) step=%0d arr=%b rdy=%b pulses=%0d expected 1 (0,0) 0 0 0 0",
                     bus.oob_err, bus.pos_row, bus.pos_col, bus.step_cnt, bus.arrived,
                     bus.move_ready, pulses);
        end
        // Right, left (back to origin), then left off the west edge.
        pulse_clr();
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            bus.move_valid = 1'b1;
            bus.move       = (k == 0) ? 2'b01 : 2'b10;
            cyc();
        end
        bus.move_valid = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (bus.pos_valid) pulses++;
            cyc();
        end
        checks++;
        if ({bus.oob_err, bus.arrived, bus.pos_row, bus.pos_col, bus.step_cnt} !==
            {1'b1, 1'b0, 4'd0, 4'd0, 8'd2} || pulses !== 2) begin
            errors++;
            $display("FAIL error_left: got oob=%b arr=%b pos=(%0d,%0d) step=%0d pulses=%0d expected 1 0 (0,0) 2 2",
                     bus.oob_err, bus.arrived, bus.pos_row, bus.pos_col, bus.step_cnt, pulses);
        end
    endtask

    task automatic test_reset_midwalk();
        int pulses = 0;
        pulse_clr();
        for (int k = 0; k < 3; k++) begin
            bus.move_valid = 1'b1;
            bus.move       = 2'b11;
            cyc();
        end
        bus.move_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        checks++;
        if (snap() !== RST_SNAP) begin
            errors++;
            $display("FAIL midwalk_reset: got %h expected %h", snap(), RST_SNAP);
        end
        for (int c = 0; c < 15; c++) begin
            if (bus.pos_valid) pulses++;
            cyc();
        end
        checks++;
        if (snap() !== RST_SNAP || pulses !== 0) begin
            errors++;
            $display("FAIL midwalk_discard: got %h pulses %0d expected %h pulses 0",
                     snap(), pulses, RST_SNAP);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.move_valid = 1'b0;
        bus.move       = 2'b00;
        test_reset();
        test_latency();
        test_backpressure();
        test_arrival();
        test_restart();
        test_error();
        test_reset_midwalk();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
